serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand set a/b/bin presented.
REQ-005 Port: in_ready  output  1  block can accept an operand set.
REQ-006 Port: a  input  WIDTH  minuend, unsigned.
REQ-007 Port: b  input  WIDTH  subtrahend, unsigned.
REQ-008 Port: bin  input  1  borrow-in.
REQ-009 Port: out_valid  output  1  diff/bout hold a completed result.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: diff  output  WIDTH  difference.
REQ-012 Port: bout  output  1  borrow-out.
REQ-013 Port (only with SERIAL_SUB_OVF_EN): ovf  output  1  two's-complement overflow.

Function
REQ-014 The block SHALL be a bit-serial full subtractor: one 1-bit subtract stage plus a borrow flip-flop, processing one bit per cycle, LSB first.
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE with in_valid=1 SHALL capture a, b, bin, clear the bit counter, load borrow with bin, and enter BUSY.
REQ-018 In BUSY, bit i (cycle i, i=0..WIDTH-1) SHALL compute d_i = a_i ^ b_i ^ br and br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-019 After the bit WIDTH-1 edge, the FSM SHALL enter DONE; out_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-020 In DONE, diff SHALL equal (a - b - bin) mod 2^WIDTH, and bout SHALL be 1 iff a < b + bin (unsigned).
REQ-021 diff, bout (and ovf) SHALL be stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 DONE with out_ready=1 SHALL return to IDLE on that edge; in_ready SHALL rise on the following cycle, with no same-cycle reload.
REQ-023 in_valid, a, b and bin SHALL be ignored outside IDLE; changing them in BUSY SHALL NOT affect the result.
REQ-024 diff/bout SHALL retain the last completed result in IDLE and BUSY until the next DONE.
REQ-025 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, counter=0, borrow=0.
REQ-027 Reset asserted during BUSY or DONE SHALL abort the operation and discard the result; no out_valid pulse SHALL follow.
REQ-028 After rst_n deasserts, the first operand set SHALL be accepted on the first rising edge with in_valid=1.

Configuration
REQ-029 Macro SERIAL_SUB_OVF_EN SHALL control the ovf port and its logic.
REQ-030 With SERIAL_SUB_OVF_EN defined, ovf SHALL be 1 in DONE iff a[W-1] != b[W-1] and diff[W-1] != a[W-1]; ovf SHALL be held like diff.
REQ-031 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent, with all other behaviour unchanged.

Verification (WIDTH=8)
REQ-032 a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0; out_valid 8 edges after accept.
REQ-033 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b -> diff/bout stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-035 Assert rst_n=0 during bit 4 of a=0xAA-0x55 -> out_valid=0, diff=0 at once; after release, new a=0x10, b=0x01 -> diff=0x0F, bout=0.
REQ-036 With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x05, b=0x03 -> ovf=0.
REQ-037 Back-to-back: hold in_valid=1 and out_ready=1 across 8 exhaustive 1-bit-pattern operand sets -> each result correct, one operation per WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor, LSB first, valid/ready on both sides.
// Optional SERIAL_SUB_OVF_EN adds the two's-complement ovf output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_nx;
  logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  assign w_ai    = r_a[0];
  assign w_bi    = r_b[0];
  assign w_d     = w_ai ^ w_bi ^ r_br;
  assign w_br_nx = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = BUSY;
      BUSY: if (w_last) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands shift right so the active bit is always at index 0;
  // result bits shift in from the MSB side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_diff <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= bin;
        r_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_nx;
        r_acc <= {w_d, r_acc[WIDTH-1:1]};
        if (w_last) begin
          r_diff <= {w_d, r_acc[WIDTH-1:1]};
          r_bout <= w_br_nx;
`ifdef SERIAL_SUB_OVF_EN
          r_ovf  <= (w_ai ^ w_bi) & (w_d ^ w_ai);
`endif
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized bench for serial_subtractor (WIDTH=8)
// against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .bin(bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf),
`endif
    .bout(bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic c);
    int d;
    d = int'(x) - int'(y) - int'(c);
    return d[W-1:0];
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x,
                                    input logic [W-1:0] y,
                                    input logic c);
    return int'(x) < (int'(y) + int'(c));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic c);
    logic [W-1:0] d;
    d = ref_diff(x, y, c);
    return (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = x;
    b = y;
    bin = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic c,
                     input int hold);
    int lat;
    accept(x, y, c);
    wait_done(lat);
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ref_diff(x, y, c)});
    chk({tag, "_bout"}, {31'd0, bout}, {31'd0, ref_bout(x, y, c)});
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ref_ovf(x, y, c)});
`endif
    for (int i = 0; i < hold; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rdy"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int lat;
    int seen;
    int t_prev;
    logic [W-1:0] hd;
    logic         hb;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic         ec;

    #1;
    chk("rst_state", {29'd0, in_ready, out_valid, bout}, 32'd4);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run("sub_5_3", 8'h05, 8'h03, 1'b0, 0);
    run("sub_3_5", 8'h03, 8'h05, 1'b0, 1);
    run("sub_0_0_b", 8'h00, 8'h00, 1'b1, 0);
`ifdef SERIAL_SUB_OVF_EN
    run("ovf_80_01", 8'h80, 8'h01, 1'b0, 0);
`endif

    // Hold the result while the producer side toggles.
    accept(8'h40, 8'h11, 1'b0);
    wait_done(lat);
    chk("hold_lat", lat, W);
    hd = diff;
    hb = bout;
    chk("hold_diff0", {24'd0, hd}, 32'h2F);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      tick();
      chk("hold_stable", {22'd0, in_ready, out_valid, bout, diff},
          {22'd0, 1'b0, 1'b1, 1'b0, 8'h2F});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    chk("hold_keep", {23'd0, bout, diff}, {23'd0, hb, hd});

    // Abort during bit 4.
    accept(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_now", {21'd0, in_ready, out_valid, bout, diff}, 32'h400);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run("post_abort", 8'h10, 8'h01, 1'b0, 0);

    // Back-to-back over all 1-bit patterns.
    in_valid = 1'b1;
    out_ready = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      ex = k[2] ? 8'hFF : 8'h00;
      ey = k[1] ? 8'hFF : 8'h00;
      ec = k[0];
      a = ex;
      b = ey;
      bin = ec;
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (k > 0) chk("b2b_period", cyc - t_prev, W + 2);
      t_prev = cyc;
      a = ~ex;
      b = ~ey;
      bin = ~ec;
      wait_done(lat);
      chk("b2b_lat", lat, W);
      chk("b2b_res", {23'd0, bout, diff},
          {23'd0, ref_bout(ex, ey, ec), ref_diff(ex, ey, ec)});
      if (k == 7) in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b0;

    for (int n = 0; n < 24; n++) begin
      run("rand", W'($urandom), W'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
